// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared defines for the fetch PC sequencer.
// Contents: RESET_PC_DEFAULT (boot fetch address) and the sequencer state encoding.
package pc_sequencer_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory request bus between the PC sequencer and imem.
// Signals: imem_req (request), imem_addr (fetch address), imem_ready (memory accept).
// A transfer happens on a rising clk edge where imem_req and imem_ready are both 1.
// Modports: master = sequencer side, slave = memory side.
interface pc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   modport master (output imem_req, output imem_addr, input imem_ready);
   modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer_redirect_buf.sv
// redirect_buf: one-entry pending redirect buffer for flushes that arrive while a request waits.
// Ports: clk, rst (async active-high), set/target_in (capture, latest wins),
//        clr (drop entry), valid/target (current entry).
module redirect_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        set,
   input  logic        clr,
   input  logic [31:0] target_in,
   output logic        valid,
   output logic [31:0] target
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid  <= 1'b0;
         target <= '0;
      end else if (set) begin
         valid  <= 1'b1;
         target <= target_in;
      end else if (clr) begin
         valid  <= 1'b0;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register and instruction-memory request sequencer.
// Ports: clk, rst (async active-high), stall (hold fetch), flush/flush_pc (redirect pulse),
//        npc_in (next PC computed from pc), pc (current fetch PC), imem (request bus, master),
//        if_valid/if_pc (IF/ID fetch register), addr_misalign (sticky misaligned-fetch flag).
// Option: define PC_SEQ_ALIGN_CHECK_EN to flag misaligned fetches and force imem_addr[1:0]=00.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [31:0]           flush_pc,
   input  logic [31:0]           npc_in,
   output logic [31:0]           pc,
   pc_sequencer_if.master        imem,
   output logic                  if_valid,
   output logic [31:0]           if_pc,
   output logic                  addr_misalign
);
   state_t      state, state_d;
   logic [31:0] pc_d, if_pc_d, pend_pc;
   logic        if_valid_d, pend_valid, buf_set, buf_clr, xfer;

   assign xfer          = (state == REQ) && imem.imem_ready;
   assign imem.imem_req = (state == REQ);

   redirect_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .set       (buf_set),
      .clr       (buf_clr),
      .target_in (flush_pc),
      .valid     (pend_valid),
      .target    (pend_pc)
   );

   always_comb begin
      state_d    = state;
      pc_d       = pc;
      if_valid_d = if_valid;
      if_pc_d    = if_pc;
      buf_set    = 1'b0;
      buf_clr    = 1'b0;
      case (state)
         IDLE: begin
            state_d = REQ;
            if (flush) begin
               pc_d       = flush_pc;
               if_valid_d = 1'b0;
            end
         end
         REQ: begin
            if_valid_d = 1'b0;
            if (xfer) begin
               buf_clr = 1'b1;
               // a redirect (same-cycle or pending) turns this fetch into a discard
               if (flush)
                  pc_d = flush_pc;
               else if (pend_valid)
                  pc_d = pend_pc;
               else begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc;
                  if (stall)
                     state_d = HOLD;
                  else
                     pc_d = npc_in;
               end
            end else if (flush) begin
               // the outstanding request keeps its address; remember where to go afterwards
               buf_set = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d       = flush_pc;
               if_valid_d = 1'b0;
               state_d    = REQ;
            end else if (!stall) begin
               pc_d       = npc_in;
               if_valid_d = 1'b0;
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         if_valid <= 1'b0;
         if_pc    <= '0;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         if_valid <= if_valid_d;
         if_pc    <= if_pc_d;
      end
   end

`ifdef PC_SEQ_ALIGN_CHECK_EN
   assign imem.imem_addr = {pc[31:2], 2'b00};
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr_misalign <= 1'b0;
      else if (xfer && (pc[1:0] != 2'b00))
         addr_misalign <= 1'b1;
   end
`else
   assign imem.imem_addr = pc;
   assign addr_misalign  = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer with a fetch scoreboard.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [31:0] npc_in, pc, if_pc;
   logic        if_valid, addr_misalign;
   logic        npc_ovr = 1'b0;
   logic [31:0] npc_val = '0;
   logic [31:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;

`ifdef PC_SEQ_ALIGN_CHECK_EN
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_3000;
   localparam logic [31:0] EXP_MIS_FLAG = 32'd1;
`else
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_3002;
   localparam logic [31:0] EXP_MIS_FLAG = 32'd0;
`endif

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .npc_in        (npc_in),
      .pc            (pc),
      .imem          (bus.master),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .addr_misalign (addr_misalign)
   );

   always #5 clk = ~clk;

   assign npc_in = npc_ovr ? npc_val : pc + 32'd4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One clock; a completed, non-discarded fetch is compared against the scoreboard.
   task automatic step();
      logic x;
      x = bus.imem_req && bus.imem_ready;
      @(posedge clk);
      #1;
      if (x && if_valid) begin
         check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("fetch_pc", if_pc, exp_q.pop_front());
      end
   endtask

   task automatic check_reset();
      check("rst_pc", pc, 32'h3000);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, 32'h3000);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_misalign", 32'(addr_misalign), 32'd0);
   endtask

   initial begin
      bus.imem_ready = 1'b0;
      step();
      step();
      check_reset();
      rst = 1'b0;
      bus.imem_ready = 1'b1;
      check("idle_req", 32'(bus.imem_req), 32'd0);
      // sequential fetch at one fetch per cycle
      step();
      check("seq_req", 32'(bus.imem_req), 32'd1);
      check("seq_addr0", bus.imem_addr, 32'h3000);
      exp_q.push_back(32'h3000);
      step();
      check("seq_addr1", bus.imem_addr, 32'h3004);
      check("seq_valid", 32'(if_valid), 32'd1);
      // stall on the 3004 transfer for three cycles
      stall = 1'b1;
      exp_q.push_back(32'h3004);
      step();
      for (int i = 0; i < 2; i++) begin
         check("hold_req", 32'(bus.imem_req), 32'd0);
         check("hold_if_pc", if_pc, 32'h3004);
         check("hold_valid", 32'(if_valid), 32'd1);
         step();
      end
      check("hold_req", 32'(bus.imem_req), 32'd0);
      stall = 1'b0;
      step();
      check("rel_addr", bus.imem_addr, 32'h3008);
      check("rel_valid", 32'(if_valid), 32'd0);
      // flush while waiting: the outstanding fetch is discarded
      bus.imem_ready = 1'b0;
      flush = 1'b1;
      flush_pc = 32'h4180;
      step();
      flush = 1'b0;
      check("wait_addr", bus.imem_addr, 32'h3008);
      step();
      check("wait_addr", bus.imem_addr, 32'h3008);
      bus.imem_ready = 1'b1;
      step();
      check("disc_valid", 32'(if_valid), 32'd0);
      check("redir_addr", bus.imem_addr, 32'h4180);
      exp_q.push_back(32'h4180);
      step();
      // two flushes while waiting: latest wins
      bus.imem_ready = 1'b0;
      flush = 1'b1;
      flush_pc = 32'h5000;
      step();
      flush_pc = 32'h6000;
      step();
      flush = 1'b0;
      step();
      check("latest_hold", bus.imem_addr, 32'h4184);
      bus.imem_ready = 1'b1;
      step();
      check("latest_addr", bus.imem_addr, 32'h6000);
      exp_q.push_back(32'h6000);
      step();
      // flush together with stall on a transfer: flush wins
      stall = 1'b1;
      flush = 1'b1;
      flush_pc = 32'h7000;
      step();
      check("fs_req", 32'(bus.imem_req), 32'd1);
      check("fs_addr", bus.imem_addr, 32'h7000);
      check("fs_valid", 32'(if_valid), 32'd0);
      flush = 1'b0;
      exp_q.push_back(32'h7000);
      step();
      check("fs_hold_req", 32'(bus.imem_req), 32'd0);
      // flush with stall while in HOLD
      flush = 1'b1;
      flush_pc = 32'h7100;
      step();
      check("fh_req", 32'(bus.imem_req), 32'd1);
      check("fh_addr", bus.imem_addr, 32'h7100);
      check("fh_valid", 32'(if_valid), 32'd0);
      flush = 1'b0;
      stall = 1'b0;
      // misaligned next PC
      npc_ovr = 1'b1;
      npc_val = 32'h3002;
      exp_q.push_back(32'h7100);
      step();
      npc_ovr = 1'b0;
      check("mis_addr", bus.imem_addr, EXP_MIS_ADDR);
      check("mis_pre", 32'(addr_misalign), 32'd0);
      exp_q.push_back(32'h3002);
      step();
      check("mis_flag", 32'(addr_misalign), EXP_MIS_FLAG);
      flush = 1'b1;
      flush_pc = 32'h4000;
      step();
      flush = 1'b0;
      check("mis_sticky", 32'(addr_misalign), EXP_MIS_FLAG);
      check("mis_redir", bus.imem_addr, 32'h4000);
      // reset while waiting on imem_ready
      bus.imem_ready = 1'b0;
      step();
      step();
      check("pre_rst_addr", bus.imem_addr, 32'h4000);
      rst = 1'b1;
      #1;
      check_reset();
      step();
      check_reset();
      rst = 1'b0;
      check("post_idle_req", 32'(bus.imem_req), 32'd0);
      bus.imem_ready = 1'b1;
      step();
      check("post_req", 32'(bus.imem_req), 32'd1);
      check("post_addr", bus.imem_addr, 32'h3000);
      exp_q.push_back(32'h3000);
      step();
      check("post_next", bus.imem_addr, 32'h3004);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
